// File: rtl/board_dealer.sv
// board_dealer -- community-card sequencer for the poker table.
//
// Pulls cards from the deck over a ready/valid handshake. Before each round
// it burns one card, then deals the flop (3 cards), the turn (1) and the
// river (1). Codes above 51 and codes already on the board are rejected.
//
// Optional build macro: AUTO_ADVANCE_EN. When it is defined, a seconds
// counter also advances the rounds. The counter acts in SHOW and DONE after
// ROUND_SECS cycles. Without the macro, only the advance port moves rounds.
//
// Ports:
//   clk_sec     in   1   1 Hz system tick clock
//   rst         in   1   asynchronous, active-high reset
//   advance     in   1   one-cycle request to move to the next round
//   new_hand    in   1   one-cycle abort/clear; has priority over advance
//   deck_card   in   6   card offered by the deck
//   deck_valid  in   1   deck_card is valid this cycle
//   deal_ready  out  1   dealer accepts a card this cycle (decoded from state)
//   num         out  2   cards shown in the current round: 0, 1 or 3
//   card1..3    out  6   cards of the current round; unused slots = EMPTY_CODE
//   board       out  30  five board slots, slot i at [6i+5:6i]
//   round       out  2   0 preflop, 1 flop, 2 turn, 3 river
//   dup_err     out  1   sticky reject flag; cleared by rst or new_hand
module board_dealer #(
  parameter logic [5:0]  EMPTY_CODE = 6'd63,
  parameter int unsigned ROUND_SECS = 10
) (
  input  logic        clk_sec,
  input  logic        rst,
  input  logic        advance,
  input  logic        new_hand,
  input  logic [5:0]  deck_card,
  input  logic        deck_valid,
  output logic        deal_ready,
  output logic [1:0]  num,
  output logic [5:0]  card1,
  output logic [5:0]  card2,
  output logic [5:0]  card3,
  output logic [29:0] board,
  output logic [1:0]  round,
  output logic        dup_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BURN = 3'd1,
    DEAL = 3'd2,
    SHOW = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [29:0] EMPTY_BOARD = {5{EMPTY_CODE}};

  state_t     state_r;
  logic [1:0] need_r;   // cards still to deal in this round
  logic [2:0] dealt_r;  // next free board slot
  logic [1:0] pos_r;    // next card slot within this round
  logic       xfer_s;
  logic       reject_s;
  logic       adv_s;

  // True when code already sits in one of the five board slots.
  function automatic logic on_board(input logic [29:0] b, input logic [5:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hit = hit | (b[6*i +: 6] == code);
    end
    return hit;
  endfunction

  assign deal_ready = (state_r == BURN) || (state_r == DEAL);
  assign xfer_s     = deal_ready && deck_valid;
  assign reject_s   = (deck_card > 6'd51) || on_board(board, deck_card);

`ifdef AUTO_ADVANCE_EN
  localparam int unsigned CW = (ROUND_SECS > 1) ? $clog2(ROUND_SECS) : 1;

  logic [CW-1:0] secs_r;
  logic          auto_adv_s;

  assign auto_adv_s = ((state_r == SHOW) || (state_r == DONE)) &&
                      (secs_r == CW'(ROUND_SECS - 1));
  assign adv_s      = advance | auto_adv_s;

  // Seconds spent in SHOW/DONE; restarts whenever either state is left or
  // re-entered (SHOW->DONE only happens on an advance, which clears it).
  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      secs_r <= CW'(0);
    end else if (new_hand || adv_s) begin
      secs_r <= CW'(0);
    end else if ((state_r == SHOW) || (state_r == DONE)) begin
      secs_r <= secs_r + CW'(1);
    end else begin
      secs_r <= CW'(0);
    end
  end
`else
  logic [31:0] unused_secs_s;

  assign unused_secs_s = ROUND_SECS;
  assign adv_s         = advance;
`endif

  // Dealing sequencer and all registered outputs.
  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      need_r  <= 2'd0;
      dealt_r <= 3'd0;
      pos_r   <= 2'd0;
      round   <= 2'd0;
      num     <= 2'd0;
      card1   <= EMPTY_CODE;
      card2   <= EMPTY_CODE;
      card3   <= EMPTY_CODE;
      board   <= EMPTY_BOARD;
      dup_err <= 1'b0;
    end else if (new_hand) begin
      // Any card handed over this cycle is consumed but dropped.
      state_r <= IDLE;
      need_r  <= 2'd0;
      dealt_r <= 3'd0;
      pos_r   <= 2'd0;
      round   <= 2'd0;
      num     <= 2'd0;
      card1   <= EMPTY_CODE;
      card2   <= EMPTY_CODE;
      card3   <= EMPTY_CODE;
      board   <= EMPTY_BOARD;
      dup_err <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (adv_s) begin
            round   <= 2'd1;
            need_r  <= 2'd3;
            pos_r   <= 2'd0;
            num     <= 2'd0;
            card1   <= EMPTY_CODE;
            card2   <= EMPTY_CODE;
            card3   <= EMPTY_CODE;
            state_r <= BURN;
          end
        end
        BURN: begin
          // The burnt card is thrown away without any checking.
          if (xfer_s) begin
            state_r <= DEAL;
          end
        end
        DEAL: begin
          if (xfer_s) begin
            if (reject_s) begin
              dup_err <= 1'b1;
            end else begin
              case (dealt_r)
                3'd0:    board[5:0]   <= deck_card;
                3'd1:    board[11:6]  <= deck_card;
                3'd2:    board[17:12] <= deck_card;
                3'd3:    board[23:18] <= deck_card;
                3'd4:    board[29:24] <= deck_card;
                default: board        <= board;
              endcase
              case (pos_r)
                2'd0:    card1 <= deck_card;
                2'd1:    card2 <= deck_card;
                2'd2:    card3 <= deck_card;
                default: card3 <= card3;
              endcase
              dealt_r <= dealt_r + 3'd1;
              pos_r   <= pos_r + 2'd1;
              need_r  <= need_r - 2'd1;
              if (need_r == 2'd1) begin
                num     <= (round == 2'd1) ? 2'd3 : 2'd1;
                state_r <= SHOW;
              end
            end
          end
        end
        SHOW: begin
          if (adv_s) begin
            if (round == 2'd3) begin
              state_r <= DONE;
            end else begin
              round   <= round + 2'd1;
              need_r  <= 2'd1;
              pos_r   <= 2'd0;
              num     <= 2'd0;
              card1   <= EMPTY_CODE;
              card2   <= EMPTY_CODE;
              card3   <= EMPTY_CODE;
              state_r <= BURN;
            end
          end
        end
        DONE: begin
          if (adv_s) begin
            state_r <= IDLE;
            need_r  <= 2'd0;
            dealt_r <= 3'd0;
            pos_r   <= 2'd0;
            round   <= 2'd0;
            num     <= 2'd0;
            card1   <= EMPTY_CODE;
            card2   <= EMPTY_CODE;
            card3   <= EMPTY_CODE;
            board   <= EMPTY_BOARD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/board_dealer.md
Name: board_dealer

Overview:
- Community-card sequencer for the poker table, clocked by the 1 Hz clk_sec.
- Pulls cards from the deck/shuffler over a ready/valid handshake and burns one card before each round.
- Deals the flop (3 cards), then the turn (1) and the river (1), rejecting invalid or duplicate codes.
- Drives num/card1..card3 directly into the main-card display stage, and the full 5-card board to the hand evaluator.

Parameters:
- EMPTY_CODE, 6'd63, card code meaning "no card"; valid cards are 0..51.
- ROUND_SECS, 10, seconds before auto-advance (used only with AUTO_ADVANCE_EN).

Ports:
- clk_sec  input  1  1 Hz system tick clock.
- rst  input  1  reset, asynchronous, active-high.
- advance  input  1  one-cycle request to move to the next round (synchronous to clk_sec).
- new_hand  input  1  one-cycle request to abort and clear the board; has priority over advance.
- deck_card  input  6  card offered by the deck.
- deck_valid  input  1  deck_card is valid this cycle.
- deal_ready  output  1  dealer accepts a card this cycle; Moore, decoded from state.
- num  output  2  number of cards dealt in the current round: 0, 1 or 3.
- card1, card2, card3  output  6 each  cards of the current round; unused slots hold EMPTY_CODE.
- board  output  30  five board slots; slot i at bits [6i+5:6i]; undealt slots hold EMPTY_CODE.
- round  output  2  0 = preflop, 1 = flop, 2 = turn, 3 = river.
- dup_err  output  1  sticky: set when any card is rejected; cleared by rst or new_hand.

Behaviour:
- Reset values: state IDLE, round 0, num 0, card1..card3 = EMPTY_CODE, board = all EMPTY_CODE (30'h3FFFFFFF), deal_ready 0, dup_err 0, dealt count 0.
- Transfer rule: a card is transferred on a posedge when deal_ready && deck_valid. No other cycle consumes a card.
- States: IDLE, BURN, DEAL, SHOW, DONE.
- IDLE:
  - deal_ready = 0.
  - On advance: round <= 1, need <= 3, card1..card3 <= EMPTY_CODE, num <= 0, go to BURN.
- BURN:
  - deal_ready = 1.
  - The transferred card is discarded; no validity or duplicate check.
  - Go to DEAL on the next cycle.
- DEAL:
  - deal_ready = 1.
  - A transferred card is rejected if code > 51 or it equals any filled board slot. On reject: dup_err <= 1, stay in DEAL, need unchanged.
  - Otherwise the card is written to board slot [dealt count] and to card(k), where k = 1 + (cards dealt so far this round). Then dealt count +1, need -1.
  - When the accepted card makes need = 0: num <= 3 for the flop or 1 for turn/river, go to SHOW.
  - num stays 0 throughout BURN/DEAL.
- SHOW:
  - deal_ready = 0.
  - On advance with round < 3: round +1, need <= 1, card1..card3 <= EMPTY_CODE, num <= 0, go to BURN.
  - On advance with round = 3: go to DONE; outputs hold.
- DONE:
  - deal_ready = 0; outputs hold.
  - On advance: clear board, cards, num, round and dealt count, go to IDLE.
- advance is ignored in BURN and DEAL.
- new_hand in any state: same clear as DONE→IDLE, plus dup_err <= 0, all on the next edge.
- Simultaneous new_hand and a transfer: the card is consumed by the handshake but discarded.
- rst mid-deal: immediate return to reset values; any partially dealt round is lost.
- Duplicate compare runs against all 5 slots; EMPTY_CODE slots never match because accepted codes are ≤ 51.

Optional Feature:
- Macro: AUTO_ADVANCE_EN.
- With it defined:
  - A seconds counter clears on entry to SHOW.
  - It increments each cycle in SHOW.
  - Reaching ROUND_SECS-1 acts as an internal advance, OR'd with the advance port.
  - The counter also runs in DONE, returning to IDLE after ROUND_SECS cycles.
- Without it: only the advance port moves rounds; no counter is synthesised.

Test Plan:
- Flop: rst, pulse advance; deck offers 40 (burn), then 0, 13, 26 with deck_valid=1 → SHOW; num=3, card1..3 = 0/13/26, board slots 0..2 = 0/13/26, slots 3..4 = 63, round=1.
- Turn/river: from the flop state, advance; deck 41 (burn), 51 → num=1, card1=51, card2=card3=63, board slot3=51. Advance; deck 42 (burn), 7 → slot4=7, round=3. Advance → DONE; advance → IDLE with board all 63.
- Reject: during flop DEAL, offer 13, then 13, then 60, then 5 → board slots 0..1 = 13/5, dup_err=1, need still 1.
- Handshake stall: deck_valid low for 4 cycles in DEAL → no state or board change, deal_ready stays 1. In SHOW, deck_valid=1 → card not consumed (deal_ready=0).
- Abort: new_hand asserted after 2 flop cards → next edge IDLE, board all 63, num=0, dup_err=0. Async rst mid-BURN → outputs return to reset values immediately, without a clock edge.
- AUTO_ADVANCE_EN, ROUND_SECS=3: after the flop reaches SHOW with no advance → BURN exactly 3 cycles after SHOW entry. Without the macro → remains in SHOW indefinitely.
